qsys_serial_endpoint: RTL and testbench

QSYS_SERIAL_ENDPOINT -- requirements
Module: qsys_serial_endpoint

---
 rtl/qsys_serial_endpoint_pkg.sv | 17 +
 rtl/qsys_serial_endpoint_shifter.sv | 65 ++++++
 rtl/qsys_serial_endpoint.sv | 178 +++++++++++++++++
 tb/tb_qsys_serial_endpoint.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsys_serial_endpoint_pkg.sv
// Shared types and constants for the serial register endpoint.
// Frame/response sizes and the FSM state encoding live here.
package qsys_serial_endpoint_pkg;

    localparam int FRAME_BITS = 65;
    localparam int RESP_BITS  = 32;
    localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_IN,
        ST_ACCESS,
        ST_RESP,
        ST_SHIFT_OUT
    } state_e;

endpackage

// File: rtl/qsys_serial_endpoint_shifter.sv
// Serial frame shift-in register with bit counter, plus the
// read-response shift-out register with its own bit counter.
module serial_frame_shifter
    import qsys_serial_endpoint_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_start,
    input  logic                  in_shift,
    input  logic                  sdi,
    input  logic                  out_load,
    input  logic [31:0]           out_data,
    input  logic                  out_shift,
    output logic [FRAME_BITS-1:0] frame,
    output logic [6:0]            in_cnt,
    output logic                  out_msb,
    output logic [5:0]            out_cnt
);

    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [6:0]            cnt_q, cnt_d;
    logic [RESP_BITS-1:0]  sout_q, sout_d;
    logic [5:0]            ocnt_q, ocnt_d;

    always_comb begin
        frame_d = frame_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        ocnt_d  = ocnt_q;
        if (in_start) begin
            frame_d = {{(FRAME_BITS-1){1'b0}}, sdi};
            cnt_d   = 7'd1;
        end else if (in_shift) begin
            frame_d = {frame_q[FRAME_BITS-2:0], sdi};
            cnt_d   = cnt_q + 7'd1;
        end
        if (out_load) begin
            sout_d = out_data;
            ocnt_d = 6'd0;
        end else if (out_shift) begin
            sout_d = {sout_q[RESP_BITS-2:0], 1'b0};
            ocnt_d = ocnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
            cnt_q   <= '0;
            sout_q  <= '0;
            ocnt_q  <= '0;
        end else begin
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            ocnt_q  <= ocnt_d;
        end
    end

    assign frame   = frame_q;
    assign in_cnt  = cnt_q;
    assign out_msb = sout_q[RESP_BITS-1];
    assign out_cnt = ocnt_q;

endmodule

// File: rtl/qsys_serial_endpoint.sv
// Serial-framed register access endpoint: 65-bit command frame in,
// single register access with timeout, serial read response out.
module qsys_serial_endpoint
    import qsys_serial_endpoint_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic                  csi_MCLK_clk,
    input  logic                  rsi_MRST_reset,
    input  logic                  ser_sdi,
    input  logic                  ser_sle,
    output logic                  ser_sdo,
    output logic                  ser_srdy,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [31:0]           reg_wdata,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic [31:0]           reg_rdata,
    input  logic                  reg_ack,
    output logic                  frame_err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic                  op_q, op_d;
    logic                  err_q, err_d;
    logic                  srdy_q, srdy_d;
    logic                  sdo_q, sdo_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    logic                  in_start, in_shift;
    logic                  out_load, out_shift;
    logic [31:0]           out_data;
    logic [FRAME_BITS-1:0] frame;
    logic [6:0]            in_cnt;
    logic                  out_msb;
    logic [5:0]            out_cnt;
    logic                  unused_frame_hi;

    assign unused_frame_hi = ^frame[63:32];

    serial_frame_shifter u_shifter (
        .clk       (csi_MCLK_clk),
        .rst       (rsi_MRST_reset),
        .in_start  (in_start),
        .in_shift  (in_shift),
        .sdi       (ser_sdi),
        .out_load  (out_load),
        .out_data  (out_data),
        .out_shift (out_shift),
        .frame     (frame),
        .in_cnt    (in_cnt),
        .out_msb   (out_msb),
        .out_cnt   (out_cnt)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        op_d      = op_q;
        tmo_d     = tmo_q;
        err_d     = 1'b0;
        srdy_d    = 1'b0;
        sdo_d     = 1'b0;
        in_start  = 1'b0;
        in_shift  = 1'b0;
        out_load  = 1'b0;
        out_shift = 1'b0;
        out_data  = reg_rdata;
        unique case (state_q)
            ST_IDLE: begin
                if (ser_sle) begin
                    in_start = 1'b1;
                    state_d  = ST_SHIFT_IN;
                end
            end
            ST_SHIFT_IN: begin
                // Counter parks at FRAME_BITS+1 while an overlong frame drains.
                if (ser_sle) begin
                    if (in_cnt == 7'(FRAME_BITS)) err_d = 1'b1;
                    if (in_cnt <= 7'(FRAME_BITS)) in_shift = 1'b1;
                end else if (in_cnt == 7'(FRAME_BITS)) begin
                    addr_d  = frame[32 +: ADDR_WIDTH];
                    wdata_d = frame[31:0];
                    op_d    = frame[64];
                    wr_d    = frame[64];
                    rd_d    = ~frame[64];
                    tmo_d   = '0;
                    state_d = ST_ACCESS;
                end else begin
                    if (in_cnt < 7'(FRAME_BITS)) err_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (reg_ack) begin
                    wr_d     = 1'b0;
                    rd_d     = 1'b0;
                    out_load = ~op_q;
                    state_d  = ST_RESP;
                end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                    wr_d     = 1'b0;
                    rd_d     = 1'b0;
                    err_d    = 1'b1;
                    out_load = 1'b1;
                    out_data = ERR_RDATA;
                    state_d  = ST_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_RESP: begin
                srdy_d = 1'b1;
                if (op_q) begin
                    state_d = ST_IDLE;
                end else begin
                    sdo_d     = out_msb;
                    out_shift = 1'b1;
                    state_d   = ST_SHIFT_OUT;
                end
            end
            ST_SHIFT_OUT: begin
                if (out_cnt == 6'(RESP_BITS)) begin
                    state_d = ST_IDLE;
                end else begin
                    srdy_d    = 1'b1;
                    sdo_d     = out_msb;
                    out_shift = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            op_q    <= 1'b0;
            err_q   <= 1'b0;
            srdy_q  <= 1'b0;
            sdo_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            op_q    <= op_d;
            err_q   <= err_d;
            srdy_q  <= srdy_d;
            sdo_q   <= sdo_d;
            tmo_q   <= tmo_d;
        end
    end

    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr    = wr_q;
    assign reg_rd    = rd_q;
    assign frame_err = err_q;
    assign ser_srdy  = srdy_q;
    assign ser_sdo   = sdo_q;

endmodule

// File: tb/tb_qsys_serial_endpoint.sv
// Directed bench for the serial register endpoint.
// A negedge monitor accumulates activity that each test checks.
module tb_qsys_serial_endpoint;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sdi = 1'b0;
    logic        sle = 1'b0;
    logic        sdo;
    logic        srdy;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_rdata = '0;
    logic        reg_ack = 1'b0;
    logic        frame_err;

    int errors = 0;
    int checks = 0;

    int          wr_cnt, rd_cnt, err_cnt;
    int          srdy_cnt, srdy_rises, sdo_bad;
    logic        srdy_prev;
    logic [31:0] resp;
    logic [7:0]  last_addr;
    logic [31:0] last_wdata;

    qsys_serial_endpoint dut (
        .csi_MCLK_clk   (clk),
        .rsi_MRST_reset (rst),
        .ser_sdi        (sdi),
        .ser_sle        (sle),
        .ser_sdo        (sdo),
        .ser_srdy       (srdy),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_wr         (reg_wr),
        .reg_rd         (reg_rd),
        .reg_rdata      (reg_rdata),
        .reg_ack        (reg_ack),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_wr) begin
                wr_cnt++;
                last_addr  = reg_addr;
                last_wdata = reg_wdata;
            end
            if (reg_rd) begin
                rd_cnt++;
                last_addr = reg_addr;
            end
            if (frame_err) err_cnt++;
            if (srdy) begin
                srdy_cnt++;
                resp = {resp[30:0], sdo};
                if (!srdy_prev) srdy_rises++;
            end else if (sdo) begin
                sdo_bad++;
            end
            srdy_prev = srdy;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        wr_cnt     = 0;
        rd_cnt     = 0;
        err_cnt    = 0;
        srdy_cnt   = 0;
        srdy_rises = 0;
        sdo_bad    = 0;
        srdy_prev  = 1'b0;
        resp       = '0;
        last_addr  = '0;
        last_wdata = '0;
    endtask

    task automatic send_frame(input logic op, input logic [31:0] a,
                              input logic [31:0] d, input int nbits);
        logic [64:0] f;
        f = {op, a, d};
        for (int i = 0; i < nbits; i++) begin
            sle = 1'b1;
            sdi = (i < 65) ? f[64-i] : 1'b0;
            tick;
        end
        sle = 1'b0;
        sdi = 1'b0;
    endtask

    // ack driven in the d-th ACCESS cycle (d=1: zero-wait)
    task automatic ack_after(input int d, input logic [31:0] rd);
        tick;
        repeat (d - 1) tick;
        reg_ack   = 1'b1;
        reg_rdata = rd;
        tick;
        reg_ack   = 1'b0;
        reg_rdata = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if ({srdy, sdo, reg_wr, reg_rd, frame_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {srdy, sdo, reg_wr, reg_rd, frame_err});
        end
        checks++;
        if (reg_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 00", reg_addr);
        end
        checks++;
        if (reg_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_wdata: got %h expected 0", reg_wdata);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_write;
        clear_mon;
        send_frame(1'b1, 32'h0000_0012, 32'hCAFEF00D, 65);
        ack_after(3, 32'h0);
        repeat (20) tick;
        checks++;
        if (wr_cnt !== 3) begin
            errors++;
            $display("FAIL wr_len: got %0d expected 3", wr_cnt);
        end
        checks++;
        if (rd_cnt !== 0) begin
            errors++;
            $display("FAIL wr_no_rd: got %0d expected 0", rd_cnt);
        end
        checks++;
        if (last_addr !== 8'h12) begin
            errors++;
            $display("FAIL wr_addr: got %h expected 12", last_addr);
        end
        checks++;
        if (last_wdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wr_data: got %h expected cafef00d", last_wdata);
        end
        checks++;
        if (srdy_cnt !== 1) begin
            errors++;
            $display("FAIL wr_srdy: got %0d expected 1", srdy_cnt);
        end
        checks++;
        if (err_cnt !== 0) begin
            errors++;
            $display("FAIL wr_err: got %0d expected 0", err_cnt);
        end
    endtask

    task automatic test_read;
        clear_mon;
        send_frame(1'b0, 32'hABCD_0040, 32'h0, 65);
        ack_after(1, 32'h12345678);
        repeat (45) tick;
        checks++;
        if (rd_cnt !== 1) begin
            errors++;
            $display("FAIL rd_len: got %0d expected 1", rd_cnt);
        end
        checks++;
        if (last_addr !== 8'h40) begin
            errors++;
            $display("FAIL rd_addr: got %h expected 40", last_addr);
        end
        checks++;
        if (srdy_cnt !== 32 || srdy_rises !== 1) begin
            errors++;
            $display("FAIL rd_srdy: got %0d/%0d expected 32/1",
                     srdy_cnt, srdy_rises);
        end
        checks++;
        if (resp !== 32'h12345678) begin
            errors++;
            $display("FAIL rd_resp: got %h expected 12345678", resp);
        end
        checks++;
        if (sdo_bad !== 0 || wr_cnt !== 0) begin
            errors++;
            $display("FAIL rd_quiet: got sdo_bad=%0d wr=%0d expected 0/0",
                     sdo_bad, wr_cnt);
        end
    endtask

    task automatic test_short_frame;
        clear_mon;
        send_frame(1'b1, 32'h0000_0012, 32'h1, 40);
        repeat (20) tick;
        checks++;
        if (err_cnt !== 1) begin
            errors++;
            $display("FAIL short_err: got %0d expected 1", err_cnt);
        end
        checks++;
        if (wr_cnt !== 0 || rd_cnt !== 0) begin
            errors++;
            $display("FAIL short_acc: got wr=%0d rd=%0d expected 0/0",
                     wr_cnt, rd_cnt);
        end
    endtask

    task automatic test_long_frame;
        clear_mon;
        send_frame(1'b1, 32'h0000_0033, 32'h2, 70);
        repeat (10) tick;
        checks++;
        if (err_cnt !== 1) begin
            errors++;
            $display("FAIL long_err: got %0d expected 1", err_cnt);
        end
        checks++;
        if (wr_cnt !== 0 || rd_cnt !== 0) begin
            errors++;
            $display("FAIL long_acc: got wr=%0d rd=%0d expected 0/0",
                     wr_cnt, rd_cnt);
        end
        send_frame(1'b1, 32'h0000_0034, 32'h5, 65);
        ack_after(1, 32'h0);
        repeat (10) tick;
        checks++;
        if (wr_cnt !== 1 || last_addr !== 8'h34) begin
            errors++;
            $display("FAIL long_recover: got wr=%0d addr=%h expected 1/34",
                     wr_cnt, last_addr);
        end
    endtask

    task automatic test_timeout;
        clear_mon;
        send_frame(1'b0, 32'h0000_0099, 32'h0, 65);
        repeat (256 + 50) tick;
        checks++;
        if (rd_cnt !== 256) begin
            errors++;
            $display("FAIL tmo_len: got %0d expected 256", rd_cnt);
        end
        checks++;
        if (err_cnt !== 1) begin
            errors++;
            $display("FAIL tmo_err: got %0d expected 1", err_cnt);
        end
        checks++;
        if (resp !== 32'hDEADBEEF || srdy_cnt !== 32) begin
            errors++;
            $display("FAIL tmo_resp: got %h/%0d expected deadbeef/32",
                     resp, srdy_cnt);
        end
    endtask

    task automatic test_reset_mid;
        clear_mon;
        send_frame(1'b1, 32'h0000_0021, 32'hFFFFFFFF, 30);
        rst = 1'b1;
        tick;
        checks++;
        if ({reg_wr, frame_err} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_out: got %b expected 00",
                     {reg_wr, frame_err});
        end
        tick;
        rst = 1'b0;
        repeat (80) tick;
        send_frame(1'b0, 32'h0000_005A, 32'h0, 65);
        ack_after(2, 32'hA5A55A5A);
        repeat (45) tick;
        checks++;
        if (wr_cnt !== 0 || err_cnt !== 0) begin
            errors++;
            $display("FAIL rstmid_nowr: got wr=%0d err=%0d expected 0/0",
                     wr_cnt, err_cnt);
        end
        checks++;
        if (rd_cnt !== 2 || last_addr !== 8'h5A) begin
            errors++;
            $display("FAIL rstmid_rd: got %0d/%h expected 2/5a",
                     rd_cnt, last_addr);
        end
        checks++;
        if (resp !== 32'hA5A55A5A) begin
            errors++;
            $display("FAIL rstmid_resp: got %h expected a5a55a5a", resp);
        end
    endtask

    task automatic test_back_to_back;
        clear_mon;
        send_frame(1'b0, 32'h0000_0055, 32'h0, 65);
        ack_after(1, 32'h0F1E2D3C);
        repeat (5) tick;
        send_frame(1'b1, 32'h0000_0077, 32'h11111111, 65);
        repeat (40) tick;
        checks++;
        if (rd_cnt !== 1 || wr_cnt !== 0) begin
            errors++;
            $display("FAIL b2b_acc: got rd=%0d wr=%0d expected 1/0",
                     rd_cnt, wr_cnt);
        end
        checks++;
        if (resp !== 32'h0F1E2D3C || srdy_cnt !== 32) begin
            errors++;
            $display("FAIL b2b_resp: got %h/%0d expected 0f1e2d3c/32",
                     resp, srdy_cnt);
        end
        checks++;
        if (err_cnt !== 1) begin
            errors++;
            $display("FAIL b2b_err: got %0d expected 1", err_cnt);
        end
    endtask

    initial begin
        clear_mon;
        test_reset;
        test_write;
        test_read;
        test_short_frame;
        test_long_frame;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
